// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data memory responder.
package dmem_pkg;
    localparam int DMEM_DATA_W = 24;
    localparam int DMEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, one write enable and a registered read port.
module dmem_array #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: IDLE/ACCESS/DONE FSM with WAIT_CYCLES access latency.
// Optional out-of-range checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall_m,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err
);
    localparam int AW       = $clog2(DEPTH);
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;

    logic              acc_go;
    logic              acc_write;
    logic              acc_oor;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    // With zero wait cycles the access happens on the accept edge, so it uses the live request.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    assign acc_oor = 32'(acc_addr) >= DEPTH;
`else
    assign acc_oor = 1'b0;
`endif

    assign arr_addr = AW'(acc_addr % ADDR_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        zero_d  = zero_q;
        acc_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                        acc_go  = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    acc_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // zero_q forces rd_data to 0 after an out-of-range load until the next load.
        if (acc_go) begin
            err_d = acc_oor;
            if (!acc_write) begin
                zero_d = acc_oor;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    dmem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (acc_go && acc_write && !acc_oor),
        .re   (acc_go && !acc_write && !acc_oor),
        .addr (arr_addr),
        .wdata(acc_wdata),
        .rdata(arr_rdata)
    );

    assign stall_m  = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
    assign rd_valid = (state_q == DONE);
    assign addr_err = (state_q == DONE) && err_q;
    assign rd_data  = zero_q ? '0 : arr_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Expectations follow DMEM_ADDR_CHECK_EN when it is defined for the build.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [23:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [23:0] wd;
        logic [23:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        v     [2];
    logic        w     [2];
    logic [15:0] a     [2];
    logic [23:0] d     [2];
    logic        stall [2];
    logic [23:0] rdd   [2];
    logic        rdv   [2];
    logic        err   [2];

    int   n_vec;
    int   n_fail;
    exp_t sb_q [$];
    vec_t vecs [$];

    dmem_responder #(.DATA_W(24), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v[0]), .req_write(w[0]), .req_addr(a[0]),
        .req_wdata(d[0]), .stall_m(stall[0]), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .addr_err(err[0])
    );

    dmem_responder #(.DATA_W(24), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v[1]), .req_write(w[1]), .req_addr(a[1]),
        .req_wdata(d[1]), .stall_m(stall[1]), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .addr_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic popCheck(input int s, input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: got unexpected rd_valid expected no completion", name);
        end else begin
            e = sb_q.pop_front();
            checkOutput({name, "_rd_data"}, 32'(rdd[s]), 32'(e.rd));
            checkOutput({name, "_addr_err"}, 32'(err[s]), 32'(e.err));
        end
    endtask

    // One complete access; with hold=1 the request stays up (switched to alt) until DONE.
    task automatic applyStimulus(input int s, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] alt, input logic [23:0] wd,
                                 input logic [23:0] exp_rd, input logic exp_err,
                                 input int exp_stall, input bit hold, input string name);
        int stalls;
        bit done;
        v[s] = 1'b1;
        w[s] = wr;
        a[s] = addr;
        d[s] = wd;
        sb_q.push_back('{exp_rd, exp_err});
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (rdv[s]) begin
                done = 1'b1;
                checkOutput({name, "_stall_in_done"}, 32'(stall[s]), 32'd0);
                v[s] = 1'b0;
                popCheck(s, name);
            end else begin
                if (stall[s]) stalls++;
                @(posedge clk);
                @(negedge clk);
                if (hold) begin
                    a[s] = alt;
                    w[s] = ~wr;
                    d[s] = ~wd;
                end else begin
                    v[s] = 1'b0;
                end
            end
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no rd_valid expected completion", name);
        end
        checkOutput({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput({name, "_valid_one_cycle"}, 32'(rdv[s]), 32'd0);
        checkOutput({name, "_idle_stall"}, 32'(stall[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        for (int s = 0; s < 2; s++) begin
            v[s] = 1'b0;
            w[s] = 1'b0;
            a[s] = '0;
            d[s] = '0;
        end

        vecs.push_back('{1'b1, 16'd5,    24'h123456, 24'h000000, 1'b0});
        vecs.push_back('{1'b0, 16'd5,    24'h000000, 24'h123456, 1'b0});
        vecs.push_back('{1'b1, 16'd6,    24'hA5A5A5, 24'h123456, 1'b0});
        vecs.push_back('{1'b0, 16'd6,    24'h000000, 24'hA5A5A5, 1'b0});
        vecs.push_back('{1'b1, 16'd1023, 24'hFFFFFF, 24'hA5A5A5, 1'b0});
        vecs.push_back('{1'b0, 16'd1023, 24'h000000, 24'hFFFFFF, 1'b0});
        vecs.push_back('{1'b1, 16'd0,    24'h000001, 24'hFFFFFF, 1'b0});
        vecs.push_back('{1'b1, 16'h0400, 24'h0BEEF0, 24'hFFFFFF, CHK});
        vecs.push_back('{1'b0, 16'd0,    24'h000000, CHK ? 24'h000001 : 24'h0BEEF0, 1'b0});
        vecs.push_back('{1'b0, 16'h0400, 24'h000000, CHK ? 24'h000000 : 24'h0BEEF0, CHK});
        vecs.push_back('{1'b0, 16'd5,    24'h000000, 24'h123456, 1'b0});
        vecs.push_back('{1'b1, 16'd4,    24'h444444, 24'h123456, 1'b0});
        vecs.push_back('{1'b1, 16'd7,    24'h777777, 24'h123456, 1'b0});
        vecs.push_back('{1'b1, 16'd9,    24'h999999, 24'h123456, 1'b0});

        #12;
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("reset_stall_%0d", s), 32'(stall[s]), 32'd0);
            checkOutput($sformatf("reset_valid_%0d", s), 32'(rdv[s]), 32'd0);
            checkOutput($sformatf("reset_err_%0d", s), 32'(err[s]), 32'd0);
            checkOutput($sformatf("reset_rd_%0d", s), 32'(rdd[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].addr, vecs[i].wd,
                          vecs[i].exp_rd, vecs[i].exp_err, 3, 1'b0, $sformatf("vec%0d", i));
        end

        applyStimulus(0, 1'b0, 16'd7, 16'd9, 24'h0, 24'h777777, 1'b0, 3, 1'b1, "held_change");

        // Abandon a store mid-access with reset.
        v[0] = 1'b1;
        w[0] = 1'b1;
        a[0] = 16'd4;
        d[0] = 24'hABCDEF;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("midreset_in_access", 32'(stall[0]), 32'd1);
        rst  = 1'b1;
        v[0] = 1'b0;
        #1;
        checkOutput("midreset_stall", 32'(stall[0]), 32'd0);
        checkOutput("midreset_valid", 32'(rdv[0]), 32'd0);
        checkOutput("midreset_err", 32'(err[0]), 32'd0);
        checkOutput("midreset_rd", 32'(rdd[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 16'd4, 16'd4, 24'h0, 24'h444444, 1'b0, 3, 1'b0, "after_reset_load");

        applyStimulus(1, 1'b1, 16'd1, 16'd1, 24'h000011, 24'h000000, 1'b0, 1, 1'b0, "w0_store1");
        applyStimulus(1, 1'b1, 16'd2, 16'd2, 24'h000022, 24'h000000, 1'b0, 1, 1'b0, "w0_store2");

        // Back-to-back loads with req_valid held high through DONE.
        v[1] = 1'b1;
        w[1] = 1'b0;
        a[1] = 16'd1;
        sb_q.push_back('{24'h000011, 1'b0});
        #1;
        checkOutput("b2b_accept1_stall", 32'(stall[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a[1] = 16'd2;
        sb_q.push_back('{24'h000022, 1'b0});
        #1;
        checkOutput("b2b_done1_valid", 32'(rdv[1]), 32'd1);
        checkOutput("b2b_done1_stall", 32'(stall[1]), 32'd0);
        if (rdv[1]) popCheck(1, "b2b_first");
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("b2b_idle_valid", 32'(rdv[1]), 32'd0);
        checkOutput("b2b_accept2_stall", 32'(stall[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        v[1] = 1'b0;
        #1;
        checkOutput("b2b_done2_valid", 32'(rdv[1]), 32'd1);
        if (rdv[1]) popCheck(1, "b2b_second");
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("b2b_end_valid", 32'(rdv[1]), 32'd0);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the MEM stage of the pipelined processor. Accepts load/store requests addressed by the 16-bit ALU result and performs the access over a configurable number of wait cycles. Holds the pipeline via stall_m while the access is in progress. Returns 24-bit read data (RD) one cycle before the MEM/WB register captures it.

Parameters:
DATA_W, 24, data word width (matches RD / register width)
ADDR_W, 16, request address width (matches ALUOutM)
DEPTH, 1024, number of DATA_W words in the array
WAIT_CYCLES, 2, extra access cycles between accept and completion (0 allowed)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  MEM stage presents a load or store this cycle
req_write  input  1  1 = store, 0 = load; sampled with req_valid
req_addr  input  ADDR_W  word address (ALUOutM)
req_wdata  input  DATA_W  store data
stall_m  output  1  hold fetch..MEM stages; combinational
rd_data  output  DATA_W  load data (RD to MEM/WB register)
rd_valid  output  1  one-cycle pulse: access complete this cycle
addr_err  output  1  one-cycle pulse: completed access was out of range (see Optional Feature)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- FSM states: IDLE, ACCESS, DONE. Reset -> IDLE.
- IDLE:
  - req_valid=1 -> capture req_write, req_addr, req_wdata into internal registers.
  - Go to ACCESS with wait counter = WAIT_CYCLES-1, or go directly to DONE if WAIT_CYCLES=0.
  - req_valid=0 -> stay in IDLE.
- ACCESS: decrement counter each cycle; when it reaches 0, go to DONE.
- DONE:
  - Store: array written at the clock edge entering DONE.
  - Load: rd_data updated at the clock edge entering DONE.
  - rd_valid=1 for exactly this cycle; next state is always IDLE.
- stall_m = (state==IDLE && req_valid) || state==ACCESS. Low in DONE, so the MEM/WB register captures rd_data at the end of the DONE cycle.
- Latency: accept cycle to DONE = WAIT_CYCLES+1 cycles. Max throughput: one access per WAIT_CYCLES+2 cycles.
- Requests are captured at accept. Changes or deassertion of req_* while stalled are ignored, and the captured transaction always completes.
- Stores leave rd_data unchanged. rd_data holds its last load value until the next load completes.
- A request arriving in the DONE cycle is not accepted. The pipeline advances and re-presents it in IDLE the next cycle.
- Reset values:
  - state=IDLE; stall_m=0, rd_valid=0, addr_err=0, rd_data=0.
  - Array contents are not cleared.
- Reset mid-access: the transaction is abandoned and a pending store is not written. Reset has priority over everything.

Optional Feature:
DMEM_ADDR_CHECK_EN
- Defined:
  - Any address >= DEPTH is out of range.
  - Out-of-range store: write suppressed.
  - Out-of-range load: rd_data set to 0.
  - addr_err pulses with rd_valid in DONE.
- Undefined: address is taken modulo DEPTH (low clog2(DEPTH) bits) and addr_err is tied to 0.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {IDLE, ACCESS, DONE}
  - DMEM_DATA_W=24, DMEM_ADDR_W=16 constants
- Sub-module dmem_array: single-port synchronous RAM with one write enable and a registered read, DEPTH x DATA_W. The FSM lives in dmem_responder.

Test Plan:
- Reset mid-operation:
  - Assert rst during ACCESS of a store of 24'hABCDEF to addr 4.
  - Required: outputs return to reset values immediately.
  - A subsequent load of addr 4 returns its prior contents, not ABCDEF.
- Store then load, WAIT_CYCLES=2:
  - Store 24'h123456 to addr 5, then load addr 5.
  - Required: stall_m high 3 cycles per access.
  - rd_valid pulses in the 4th cycle; rd_data=24'h123456.
- WAIT_CYCLES=0, back-to-back loads of addr 1 and 2 (preloaded 24'h000011, 24'h000022):
  - Required: each access stalls 1 cycle, with DONE 1 cycle after accept.
  - rd_data sequence 000011 then 000022.
  - Second request accepted only in IDLE, never in DONE.
- Request changes while stalled:
  - Accept load addr 7; change req_addr to 9 during ACCESS.
  - Required: rd_data equals contents of addr 7.
- Out-of-range address, DEPTH=1024:
  - With DMEM_ADDR_CHECK_EN: store to addr 16'h0400 is suppressed and addr_err pulses. A load of 16'h0400 returns 0 with addr_err=1.
  - Without the macro: the same store lands in addr 0, and addr_err stays 0.
